// File: rtl/neosd_dat_rx.sv
// rtl/neosd_dat_rx.sv - SD data-block receiver: 1/4/8-line, byte output, end-bit and start-bit timeout checks
// Per-line CRC16 checking is built only when NEOSD_DAT_RX_CRC_EN is defined.
module neosd_dat_rx #(
   parameter int DAT_WIDTH = 4,
   parameter int LEN_W     = 9,
   parameter int TMO_W     = 16
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic                 tick_i,
   input  logic                 start_i,
   input  logic                 abort_i,
   input  logic [1:0]           bus_mode_i,
   input  logic [LEN_W-1:0]     blk_len_i,
   input  logic [TMO_W-1:0]     timeout_i,
   input  logic [DAT_WIDTH-1:0] sd_dat_i,
   output logic [7:0]           byte_o,
   output logic                 byte_valid_o,
   input  logic                 byte_ready_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 crc_err_o,
   output logic                 end_err_o,
   output logic                 timeout_o,
   output logic                 overrun_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_START, S_DATA, S_CRC, S_END, S_DONE
   } state_t;

   localparam logic [1:0] M1 = 2'd0;
   localparam logic [1:0] M4 = 2'd1;
   localparam logic [1:0] M8 = 2'd2;

   state_t           state_q, state_d;
   logic [1:0]       mode_q, start_mode;
   logic [LEN_W-1:0] len_q, byte_cnt_q;
   logic [TMO_W-1:0] tmo_q;
   logic [3:0]       cnt_q;
   logic [7:0]       sh_q;
   logic [7:0]       dat8, act_mask, byte_nxt;
   logic             byte_cmp, last_byte, run_tick, start_ok, byte_done;

   always_comb begin
      dat8 = '0;
      for (int i = 0; i < DAT_WIDTH; i++) dat8[i] = sd_dat_i[i];
   end

   // Modes wider than the physical bus fall back to single-line operation.
   always_comb begin
      start_mode = M1;
      if (bus_mode_i == 2'd1 && DAT_WIDTH >= 4)      start_mode = M4;
      else if (bus_mode_i == 2'd2 && DAT_WIDTH >= 8) start_mode = M8;
   end

   always_comb begin
      act_mask = 8'h01;
      byte_cmp = (cnt_q[2:0] == 3'd7);
      byte_nxt = {sh_q[6:0], dat8[0]};
      case (mode_q)
         M4: begin
            act_mask = 8'h0F;
            byte_cmp = cnt_q[0];
            byte_nxt = {sh_q[3:0], dat8[3:0]};
         end
         M8: begin
            act_mask = 8'hFF;
            byte_cmp = 1'b1;
            byte_nxt = dat8;
         end
         default: ;
      endcase
   end

   assign run_tick  = tick_i & ~abort_i;
   assign start_ok  = (state_q == S_IDLE) & start_i;
   assign byte_done = (state_q == S_DATA) & run_tick & byte_cmp;
   // blk_len 0 wraps naturally to a full 2^LEN_W-byte block.
   assign last_byte = (LEN_W'(byte_cnt_q + 1'b1) == len_q);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (abort_i && state_q != S_IDLE) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:       if (start_i) state_d = S_WAIT_START;
            S_WAIT_START: if (tick_i) begin
               if (!dat8[0])           state_d = S_DATA;
               else if (tmo_q == '0)   state_d = S_DONE;
            end
            S_DATA:       if (tick_i && byte_cmp && last_byte) state_d = S_CRC;
            S_CRC:        if (tick_i && cnt_q == 4'd15) state_d = S_END;
            S_END:        if (tick_i) state_d = S_DONE;
            S_DONE:       state_d = S_IDLE;
            default:      state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      busy_o = (state_q != S_IDLE);
      done_o = (state_q == S_DONE) & ~abort_i;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         mode_q       <= M1;
         len_q        <= '0;
         tmo_q        <= '0;
         cnt_q        <= '0;
         byte_cnt_q   <= '0;
         sh_q         <= '0;
         byte_o       <= '0;
         byte_valid_o <= 1'b0;
         end_err_o    <= 1'b0;
         timeout_o    <= 1'b0;
         overrun_o    <= 1'b0;
      end else begin
         if (start_ok) begin
            mode_q     <= start_mode;
            len_q      <= blk_len_i;
            tmo_q      <= timeout_i;
            cnt_q      <= '0;
            byte_cnt_q <= '0;
            sh_q       <= '0;
            end_err_o  <= 1'b0;
            timeout_o  <= 1'b0;
            overrun_o  <= 1'b0;
         end else if (run_tick) begin
            case (state_q)
               S_WAIT_START: if (dat8[0]) begin
                  if (tmo_q == '0) timeout_o <= 1'b1;
                  else             tmo_q     <= tmo_q - 1'b1;
               end
               S_DATA: begin
                  sh_q <= byte_nxt;
                  if (byte_cmp) begin
                     cnt_q      <= '0;
                     byte_cnt_q <= byte_cnt_q + 1'b1;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               S_CRC: cnt_q <= cnt_q + 1'b1;
               S_END: if ((dat8 & act_mask) != act_mask) end_err_o <= 1'b1;
               default: ;
            endcase
         end

         // A byte arriving while the previous one is still unaccepted is dropped.
         if (byte_done) begin
            if (!byte_valid_o || byte_ready_i) begin
               byte_o       <= byte_nxt;
               byte_valid_o <= 1'b1;
            end else begin
               overrun_o <= 1'b1;
            end
         end else if (byte_valid_o && byte_ready_i) begin
            byte_valid_o <= 1'b0;
         end
      end
   end

`ifdef NEOSD_DAT_RX_CRC_EN
   logic [15:0] crc_q [DAT_WIDTH];
   logic [15:0] rx_q  [DAT_WIDTH];
   logic        crc_bad, crc_err_q;

   // Compare including the bit arriving on the 16th CRC tick.
   always_comb begin
      crc_bad = 1'b0;
      for (int i = 0; i < DAT_WIDTH; i++)
         if (act_mask[i] && ({rx_q[i][14:0], dat8[i]} != crc_q[i])) crc_bad = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int i = 0; i < DAT_WIDTH; i++) begin
            crc_q[i] <= '0;
            rx_q[i]  <= '0;
         end
         crc_err_q <= 1'b0;
      end else if (start_ok) begin
         for (int i = 0; i < DAT_WIDTH; i++) begin
            crc_q[i] <= '0;
            rx_q[i]  <= '0;
         end
         crc_err_q <= 1'b0;
      end else if (run_tick) begin
         if (state_q == S_DATA) begin
            for (int i = 0; i < DAT_WIDTH; i++)
               if (act_mask[i])
                  crc_q[i] <= {crc_q[i][14:0], 1'b0} ^ ((crc_q[i][15] ^ dat8[i]) ? 16'h1021 : 16'h0000);
         end
         if (state_q == S_CRC) begin
            for (int i = 0; i < DAT_WIDTH; i++) rx_q[i] <= {rx_q[i][14:0], dat8[i]};
            if (cnt_q == 4'd15 && crc_bad) crc_err_q <= 1'b1;
         end
      end
   end

   assign crc_err_o = crc_err_q;
`else
   assign crc_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_neosd_dat_rx.sv
// tb/tb_neosd_dat_rx.sv - table-driven bench for neosd_dat_rx (8-line instance)
module tb_neosd_dat_rx;

   localparam int DW = 8;
   localparam int LW = 9;
   localparam int TW = 16;
`ifdef NEOSD_DAT_RX_CRC_EN
   localparam logic CRC_ON = 1'b1;
`else
   localparam logic CRC_ON = 1'b0;
`endif

   logic          clk = 1'b0, rstn = 1'b0, tick = 1'b0, start = 1'b0, abort = 1'b0, ready = 1'b1;
   logic [1:0]    mode = 2'd0;
   logic [LW-1:0] blen = '0;
   logic [TW-1:0] tmo = '0;
   logic [DW-1:0] dat = '1;
   logic [7:0]    byte_o;
   logic          byte_valid, busy, done, crc_err, end_err, timeout, overrun;

   int            n_chk = 0, n_fail = 0, done_cnt = 0;
   logic [7:0]    rx_q[$];
   logic [7:0]    tx[512];
   logic [15:0]   mcrc[8];

   typedef struct {
      logic [1:0] mode;
      int         nbytes;
      int         pat;
      int         flip_line;
      logic [7:0] end_val;
      logic       rdy;
      int         abort_after;
      int         exp_rx;
      logic       exp_crc;
      logic       exp_end;
      logic       exp_ovr;
      int         exp_done;
   } vec_t;

   vec_t vecs[9];

   always #5 clk = ~clk;

   neosd_dat_rx #(.DAT_WIDTH(DW), .LEN_W(LW), .TMO_W(TW)) dut (
      .clk_i(clk), .rstn_i(rstn), .tick_i(tick), .start_i(start), .abort_i(abort),
      .bus_mode_i(mode), .blk_len_i(blen), .timeout_i(tmo), .sd_dat_i(dat),
      .byte_o(byte_o), .byte_valid_o(byte_valid), .byte_ready_i(ready),
      .busy_o(busy), .done_o(done), .crc_err_o(crc_err), .end_err_o(end_err),
      .timeout_o(timeout), .overrun_o(overrun)
   );

   always @(negedge clk) begin
      if (byte_valid && ready) rx_q.push_back(byte_o);
      if (done) done_cnt++;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
      return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
   endfunction

   task automatic do_tick(input logic [7:0] d);
      @(posedge clk); #1;
      dat  = d;
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
   endtask

   task automatic run_block(input vec_t v, input int idx);
      int         nl, errs, w;
      logic [7:0] mask, d;
      logic [7:0] fixed [4];
      fixed = '{8'hA5, 8'h3C, 8'h0F, 8'h12};
      nl    = (v.mode == 2'd1) ? 4 : (v.mode == 2'd2) ? 8 : 1;
      mask  = (nl == 1) ? 8'h01 : (nl == 4) ? 8'h0F : 8'hFF;
      for (int i = 0; i < v.nbytes; i++)
         tx[i] = (v.pat == 0) ? 8'hFF : (v.pat == 1) ? fixed[i % 4] : 8'($urandom);
      for (int i = 0; i < 8; i++) mcrc[i] = 16'h0000;
      rx_q.delete();
      done_cnt = 0;
      ready    = v.rdy;

      @(posedge clk); #1;
      mode = v.mode; blen = LW'(v.nbytes); tmo = TW'(100); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) do_tick(8'hFF);
      do_tick(8'($urandom) & 8'hFE);

      for (int k = 0; k < v.nbytes; k++) begin
         if (v.abort_after != 0 && k == v.abort_after) break;
         for (int t = 0; t < 8 / nl; t++) begin
            d = 8'($urandom) & ~mask;
            for (int i = 0; i < nl; i++) begin
               d[i]    = tx[k][8 - nl * (t + 1) + i];
               mcrc[i] = crc_step(mcrc[i], d[i]);
            end
            do_tick(d);
         end
      end

      if (v.abort_after != 0) begin
         // abort together with a tick: the tick must not complete another byte
         @(posedge clk); #1;
         abort = 1'b1; tick = 1'b1; dat = 8'h00;
         @(posedge clk); #1;
         abort = 1'b0; tick = 1'b0;
         check($sformatf("v%0d busy after abort", idx), busy, 0);
      end else begin
         for (int t = 0; t < 16; t++) begin
            d = 8'($urandom) & ~mask;
            for (int i = 0; i < nl; i++) d[i] = mcrc[i][15 - t] ^ (i == v.flip_line && t == 5);
            do_tick(d);
         end
         do_tick((8'($urandom) & ~mask) | (v.end_val & mask));
         w = 0;
         while (busy && w < 20) begin
            @(posedge clk); #1;
            w++;
         end
         check($sformatf("v%0d busy falls", idx), busy, 0);
      end
      repeat (3) @(posedge clk);
      #1;

      check($sformatf("v%0d done count", idx), done_cnt, v.exp_done);
      check($sformatf("v%0d crc_err", idx), crc_err, v.exp_crc);
      check($sformatf("v%0d end_err", idx), end_err, v.exp_end);
      check($sformatf("v%0d overrun", idx), overrun, v.exp_ovr);
      check($sformatf("v%0d timeout", idx), timeout, 0);
      if (!v.rdy) begin
         check($sformatf("v%0d held valid", idx), byte_valid, 1);
         check($sformatf("v%0d held byte", idx), byte_o, tx[0]);
         ready = 1'b1;
         repeat (2) @(posedge clk);
         #1;
      end
      check($sformatf("v%0d rx count", idx), rx_q.size(), v.exp_rx);
      errs = 0;
      for (int i = 0; i < rx_q.size() && i < v.nbytes; i++)
         if (rx_q[i] !== tx[i]) errs++;
      check($sformatf("v%0d rx data errors", idx), errs, 0);
   endtask

   initial begin
      int n;
      int tv[2];
      //          mode  bytes pat flip end    rdy  abort exp_rx crc     end   ovr   done
      vecs[0] = '{2'd0, 512,  0,  -1,  8'hFF, 1'b1, 0,   512,   1'b0,   1'b0, 1'b0, 1};
      vecs[1] = '{2'd1, 4,    1,  -1,  8'hFF, 1'b1, 0,   4,     1'b0,   1'b0, 1'b0, 1};
      vecs[2] = '{2'd1, 4,    1,  2,   8'hFF, 1'b1, 0,   4,     CRC_ON, 1'b0, 1'b0, 1};
      vecs[3] = '{2'd1, 4,    2,  -1,  8'hFD, 1'b1, 0,   4,     1'b0,   1'b1, 1'b0, 1};
      vecs[4] = '{2'd2, 2,    1,  -1,  8'hFF, 1'b0, 0,   1,     1'b0,   1'b0, 1'b1, 1};
      vecs[5] = '{2'd2, 20,   2,  -1,  8'hFF, 1'b1, 10,  10,    1'b0,   1'b0, 1'b0, 0};
      vecs[6] = '{2'd2, 20,   2,  -1,  8'hFF, 1'b1, 0,   20,    1'b0,   1'b0, 1'b0, 1};
      vecs[7] = '{2'd3, 3,    2,  -1,  8'hFF, 1'b1, 0,   3,     1'b0,   1'b0, 1'b0, 1};
      vecs[8] = '{2'd0, 1,    2,  -1,  8'hFF, 1'b1, 0,   1,     1'b0,   1'b0, 1'b0, 1};

      repeat (3) @(posedge clk);
      #1;
      check("reset byte_o", byte_o, 0);
      check("reset byte_valid", byte_valid, 0);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset crc_err", crc_err, 0);
      check("reset end_err", end_err, 0);
      check("reset timeout", timeout, 0);
      check("reset overrun", overrun, 0);
      rstn = 1'b1;

      for (int v = 0; v < 9; v++) run_block(vecs[v], v);

      // start-bit timeout: timeout_i=N allows exactly N+1 ticks
      tv = '{3, 0};
      for (int j = 0; j < 2; j++) begin
         rx_q.delete();
         done_cnt = 0;
         @(posedge clk); #1;
         mode = 2'd1; tmo = TW'(tv[j]); start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         n = 0;
         do begin
            do_tick(8'hFF);
            n++;
            @(posedge clk); #1;
         end while (busy && n < 10);
         check($sformatf("tmo%0d ticks", tv[j]), n, tv[j] + 1);
         check($sformatf("tmo%0d timeout", tv[j]), timeout, 1);
         check($sformatf("tmo%0d done count", tv[j]), done_cnt, 1);
         check($sformatf("tmo%0d rx count", tv[j]), rx_q.size(), 0);
      end

      // asynchronous reset in the middle of a block with a byte pending and overrun set
      @(posedge clk); #1;
      ready = 1'b0; mode = 2'd2; blen = LW'(10); tmo = TW'(50); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      do_tick(8'h00);
      repeat (3) do_tick(8'h5A);
      check("pre-reset overrun", overrun, 1);
      @(posedge clk); #2;
      rstn = 1'b0;
      #1;
      check("mid reset busy", busy, 0);
      check("mid reset byte_valid", byte_valid, 0);
      check("mid reset byte_o", byte_o, 0);
      check("mid reset overrun", overrun, 0);
      @(posedge clk); #1;
      rstn  = 1'b1;
      ready = 1'b1;
      run_block(vecs[1], 9);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
